// File: rtl/lc3_mem_responder_pkg.sv
// Shared definitions for the LC-3 memory responder: MMIO map and FSM states.
package lc3_mem_responder_pkg;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RWAIT = 3'd1,
    RDONE = 3'd2,
    WWAIT = 3'd3,
    WDONE = 3'd4
  } mem_resp_states_e;

  // Full 16-bit decode; any other address goes to the (aliased) main array.
  function automatic logic is_mmio(input logic [15:0] a);
    return (a == KBSR_ADDR) || (a == KBDR_ADDR) || (a == DSR_ADDR) || (a == DDR_ADDR);
  endfunction

endpackage

// File: rtl/lc3_mem_array.sv
// Single-port word RAM with a registered read port and synchronous write.
module lc3_mem_array #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem_q [0:(1<<ADDR_W)-1];
  logic [15:0] rdata_q;

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Read register holds its value until the next enabled read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 16'h0000;
    end else if (en && !we) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lc3_mem_responder.sv
// LC-3 MAR/MDR memory responder: access FSM, latency counter, main array
// and the keyboard/display memory-mapped registers.
module lc3_mem_responder
  import lc3_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ldMAR,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        memWE,
  output logic [15:0] rdata,
  output logic        memRDY,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_data,
  output logic        kbd_ack,
  output logic        kbd_int,
  output logic        dsp_valid,
  output logic [7:0]  dsp_data,
  input  logic        dsp_ready
);

  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  // A write reaches WDONE WR_LAT cycles after memWE is sampled, so the
  // wait state covers WR_LAT-1 cycles and is skipped entirely for WR_LAT=1.
  localparam logic [CNT_W-1:0] RD_CNT_INIT = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_CNT_INIT = CNT_W'((WR_LAT > 1) ? (WR_LAT - 2) : 0);
  localparam mem_resp_states_e WR_FIRST    = (WR_LAT > 1) ? WWAIT : WDONE;

  mem_resp_states_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_rdy_q, mem_rdy_d;
  logic             rd_mmio_q, rd_mmio_d;
  logic [15:0]      mmio_rdata_q, mmio_rdata_d;
  logic             kbsr_rdy_q, kbsr_rdy_d;
  logic             kbsr_ie_q, kbsr_ie_d;
  logic [7:0]       kbdr_q, kbdr_d;
  logic             kbd_ack_q, kbd_ack_d;
  logic             kbd_int_q, kbd_int_d;
  logic             dsp_valid_q, dsp_valid_d;
  logic [7:0]       dsp_data_q, dsp_data_d;

  logic             start_rd_s;
  logic             start_wr_s;
  logic             addr_mmio_s;
  logic             kbd_clr_s;
  logic             kbd_accept_s;
  logic             dsp_load_s;
  logic             ram_en_s;
  logic             ram_we_s;
  logic [15:0]      ram_rdata_s;

  lc3_mem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .en    (ram_en_s),
    .we    (ram_we_s),
    .addr  (addr[ADDR_W-1:0]),
    .wdata (wdata),
    .rdata (ram_rdata_s)
  );

  // Access FSM: start rules, latency countdown, read capture and write commit.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_mmio_d    = rd_mmio_q;
    mmio_rdata_d = mmio_rdata_q;
    kbsr_ie_d    = kbsr_ie_q;
    dsp_data_d   = dsp_data_q;
    kbd_clr_s    = 1'b0;
    dsp_load_s   = 1'b0;
    ram_en_s     = 1'b0;
    ram_we_s     = 1'b0;
    addr_mmio_s  = is_mmio(addr);

    start_rd_s = ldMAR && (state_q != WWAIT) && (state_q != WDONE);
    start_wr_s = memWE && !ldMAR &&
                 ((state_q == IDLE) || (state_q == RWAIT) || (state_q == RDONE));

    if (start_rd_s) begin
      state_d = RWAIT;
      cnt_d   = RD_CNT_INIT;
    end else if (start_wr_s) begin
      state_d = WR_FIRST;
      cnt_d   = WR_CNT_INIT;
    end else begin
      case (state_q)
        RWAIT: begin
          if (cnt_q == CNT_W'(0)) begin
            state_d = RDONE;
            if (addr_mmio_s) begin
              rd_mmio_d = 1'b1;
              case (addr)
                KBSR_ADDR: mmio_rdata_d = {kbsr_rdy_q, kbsr_ie_q, 14'h0000};
                KBDR_ADDR: mmio_rdata_d = {8'h00, kbdr_q};
                DSR_ADDR:  mmio_rdata_d = {~dsp_valid_q, 15'h0000};
                default:   mmio_rdata_d = 16'h0000;
              endcase
              kbd_clr_s = (addr == KBDR_ADDR);
            end else begin
              rd_mmio_d = 1'b0;
              ram_en_s  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        WWAIT: begin
          if (cnt_q == CNT_W'(0)) begin
            state_d = WDONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        WDONE: begin
          state_d = IDLE;
          if (addr_mmio_s) begin
            if (addr == KBSR_ADDR) begin
              kbsr_ie_d = wdata[14];
            end else if ((addr == DDR_ADDR) && !dsp_valid_q) begin
              dsp_load_s = 1'b1;
              dsp_data_d = wdata[7:0];
            end else begin
              kbsr_ie_d = kbsr_ie_q;
            end
          end else begin
            ram_en_s = 1'b1;
            ram_we_s = 1'b1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    mem_rdy_d = (state_d == RDONE) || (state_d == WDONE);
  end

  // Keyboard and display handshakes; a KBDR read clear blocks acceptance that cycle.
  always_comb begin
    kbd_accept_s = kbd_valid && !kbsr_rdy_q && !kbd_clr_s;

    if (kbd_clr_s) begin
      kbsr_rdy_d = 1'b0;
    end else if (kbd_accept_s) begin
      kbsr_rdy_d = 1'b1;
    end else begin
      kbsr_rdy_d = kbsr_rdy_q;
    end

    if (kbd_accept_s) begin
      kbdr_d = kbd_data;
    end else begin
      kbdr_d = kbdr_q;
    end

    kbd_ack_d = kbd_accept_s;
    kbd_int_d = kbsr_rdy_d && kbsr_ie_d;

    if (dsp_load_s) begin
      dsp_valid_d = 1'b1;
    end else if (dsp_valid_q && dsp_ready) begin
      dsp_valid_d = 1'b0;
    end else begin
      dsp_valid_d = dsp_valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= CNT_W'(0);
      mem_rdy_q    <= 1'b0;
      rd_mmio_q    <= 1'b0;
      mmio_rdata_q <= 16'h0000;
      kbsr_rdy_q   <= 1'b0;
      kbsr_ie_q    <= 1'b0;
      kbdr_q       <= 8'h00;
      kbd_ack_q    <= 1'b0;
      kbd_int_q    <= 1'b0;
      dsp_valid_q  <= 1'b0;
      dsp_data_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_rdy_q    <= mem_rdy_d;
      rd_mmio_q    <= rd_mmio_d;
      mmio_rdata_q <= mmio_rdata_d;
      kbsr_rdy_q   <= kbsr_rdy_d;
      kbsr_ie_q    <= kbsr_ie_d;
      kbdr_q       <= kbdr_d;
      kbd_ack_q    <= kbd_ack_d;
      kbd_int_q    <= kbd_int_d;
      dsp_valid_q  <= dsp_valid_d;
      dsp_data_q   <= dsp_data_d;
    end
  end

  assign rdata     = rd_mmio_q ? mmio_rdata_q : ram_rdata_s;
  assign memRDY    = mem_rdy_q;
  assign kbd_ack   = kbd_ack_q;
  assign kbd_int   = kbd_int_q;
  assign dsp_valid = dsp_valid_q;
  assign dsp_data  = dsp_data_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder with RD_LAT=2, WR_LAT=2.
module tb_lc3_mem_responder;

  localparam int ADDR_W = 12;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 2;

  logic        clk;
  logic        rst;
  logic        ldMAR;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        memWE;
  logic [15:0] rdata;
  logic        memRDY;
  logic        kbd_valid;
  logic [7:0]  kbd_data;
  logic        kbd_ack;
  logic        kbd_int;
  logic        dsp_valid;
  logic [7:0]  dsp_data;
  logic        dsp_ready;

  int n_vec;
  int n_err;

  typedef struct {
    bit          is_wr;
    logic [15:0] a;
    logic [15:0] d;
  } vec_t;

  vec_t vecs [12];

  lc3_mem_responder #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT),
    .WR_LAT (WR_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ldMAR     (ldMAR),
    .addr      (addr),
    .wdata     (wdata),
    .memWE     (memWE),
    .rdata     (rdata),
    .memRDY    (memRDY),
    .kbd_valid (kbd_valid),
    .kbd_data  (kbd_data),
    .kbd_ack   (kbd_ack),
    .kbd_int   (kbd_int),
    .dsp_valid (dsp_valid),
    .dsp_data  (dsp_data),
    .dsp_ready (dsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first memRDY cycle.
  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string nm);
    addr  = a;
    ldMAR = 1'b1;
    @(negedge clk);
    ldMAR = 1'b0;
    for (int i = 1; i <= RD_LAT; i++) begin
      chk({nm, " rdy-low"}, {15'h0, memRDY}, 16'h0000);
      @(negedge clk);
    end
    chk({nm, " rdy"}, {15'h0, memRDY}, 16'h0001);
    chk({nm, " data"}, rdata, exp);
  endtask

  // Called at a negedge; returns at the negedge of the cycle after memRDY.
  task automatic wr(input logic [15:0] a, input logic [15:0] d, input string nm);
    addr  = a;
    wdata = d;
    memWE = 1'b1;
    @(negedge clk);
    for (int i = 1; i < WR_LAT; i++) begin
      chk({nm, " rdy-low"}, {15'h0, memRDY}, 16'h0000);
      @(negedge clk);
    end
    chk({nm, " rdy"}, {15'h0, memRDY}, 16'h0001);
    @(negedge clk);
    memWE = 1'b0;
    chk({nm, " rdy-once"}, {15'h0, memRDY}, 16'h0000);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    ldMAR     = 1'b0;
    addr      = 16'h0000;
    wdata     = 16'h0000;
    memWE     = 1'b0;
    kbd_valid = 1'b0;
    kbd_data  = 8'h00;
    dsp_ready = 1'b0;

    vecs[0]  = '{1'b1, 16'h0010, 16'h1234};
    vecs[1]  = '{1'b1, 16'h0020, 16'hBEEF};
    vecs[2]  = '{1'b1, 16'h0030, 16'h0AAA};
    vecs[3]  = '{1'b1, 16'h0E04, 16'h5555};
    vecs[4]  = '{1'b0, 16'h0020, 16'hBEEF};
    vecs[5]  = '{1'b0, 16'h0010, 16'h1234};
    vecs[6]  = '{1'b0, 16'h1010, 16'h1234};
    vecs[7]  = '{1'b1, 16'hFE04, 16'h1234};
    vecs[8]  = '{1'b0, 16'h0E04, 16'h5555};
    vecs[9]  = '{1'b0, 16'hFE04, 16'h8000};
    vecs[10] = '{1'b0, 16'hFE00, 16'h0000};
    vecs[11] = '{1'b0, 16'h0030, 16'h0AAA};

    // Reset values
    @(negedge clk);
    chk("rst memRDY", {15'h0, memRDY}, 16'h0000);
    chk("rst rdata", rdata, 16'h0000);
    chk("rst kbd_ack", {15'h0, kbd_ack}, 16'h0000);
    chk("rst kbd_int", {15'h0, kbd_int}, 16'h0000);
    chk("rst dsp_valid", {15'h0, dsp_valid}, 16'h0000);
    chk("rst dsp_data", {8'h00, dsp_data}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_wr) begin
        wr(vecs[i].a, vecs[i].d, $sformatf("vec%0d", i));
      end else begin
        rd(vecs[i].a, vecs[i].d, $sformatf("vec%0d", i));
      end
    end

    // Reset, then a read whose result must be held, then reset drops memRDY at once
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd(16'h0010, 16'h1234, "rst-read");
    addr = 16'h0FFF;
    @(negedge clk);
    chk("hold rdy", {15'h0, memRDY}, 16'h0001);
    chk("hold data", rdata, 16'h1234);
    rst = 1'b1;
    #1;
    chk("rst-async memRDY", {15'h0, memRDY}, 16'h0000);
    chk("rst-async rdata", rdata, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Reset while the write to x0030 is waiting
    addr  = 16'h0030;
    wdata = 16'h7777;
    memWE = 1'b1;
    @(negedge clk);
    chk("wwait rdy", {15'h0, memRDY}, 16'h0000);
    rst   = 1'b1;
    memWE = 1'b0;
    #1;
    chk("wwait rst rdy", {15'h0, memRDY}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    rd(16'h0030, 16'h0AAA, "wwait-discard");

    // Keyboard
    kbd_data  = 8'h41;
    kbd_valid = 1'b1;
    chk("kbd ack-pre", {15'h0, kbd_ack}, 16'h0000);
    @(negedge clk);
    chk("kbd ack", {15'h0, kbd_ack}, 16'h0001);
    kbd_valid = 1'b0;
    @(negedge clk);
    chk("kbd ack-once", {15'h0, kbd_ack}, 16'h0000);
    rd(16'hFE00, 16'h8000, "kbsr-ready");
    chk("kbd int-off", {15'h0, kbd_int}, 16'h0000);
    wr(16'hFE00, 16'h4000, "kbsr-ie");
    chk("kbd int-on", {15'h0, kbd_int}, 16'h0001);
    rd(16'hFE00, 16'hC000, "kbsr-both");
    kbd_data  = 8'h42;
    kbd_valid = 1'b1;
    rd(16'hFE02, 16'h0041, "kbdr");
    chk("kbdr clr ack", {15'h0, kbd_ack}, 16'h0000);
    chk("kbdr clr int", {15'h0, kbd_int}, 16'h0000);
    @(negedge clk);
    chk("kbd2 ack", {15'h0, kbd_ack}, 16'h0001);
    chk("kbd2 int", {15'h0, kbd_int}, 16'h0001);
    kbd_valid = 1'b0;
    rd(16'hFE02, 16'h0042, "kbdr2");
    rd(16'hFE00, 16'h4000, "kbsr-cleared");

    // Display
    wr(16'hFE06, 16'h0058, "ddr1");
    chk("dsp valid", {15'h0, dsp_valid}, 16'h0001);
    chk("dsp data", {8'h00, dsp_data}, 16'h0058);
    rd(16'hFE04, 16'h0000, "dsr-busy");
    wr(16'hFE06, 16'h0059, "ddr2");
    chk("dsp drop", {8'h00, dsp_data}, 16'h0058);
    dsp_ready = 1'b1;
    @(negedge clk);
    chk("dsp consumed", {15'h0, dsp_valid}, 16'h0000);
    dsp_ready = 1'b0;
    rd(16'hFE04, 16'h8000, "dsr-free");

    // ldMAR and memWE together: read starts, then memWE aborts it next cycle
    addr  = 16'h0020;
    wdata = 16'h1111;
    ldMAR = 1'b1;
    memWE = 1'b1;
    @(negedge clk);
    ldMAR = 1'b0;
    chk("prio c1", {15'h0, memRDY}, 16'h0000);
    @(negedge clk);
    chk("prio c2", {15'h0, memRDY}, 16'h0000);
    @(negedge clk);
    chk("prio wdone", {15'h0, memRDY}, 16'h0001);
    @(negedge clk);
    memWE = 1'b0;
    chk("prio no-read", {15'h0, memRDY}, 16'h0000);
    rd(16'h0020, 16'h1111, "prio-data");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
